risc_spm_control_unit: RTL and testbench
========================================

Name: risc_spm_control_unit

Overview:
- Moore/Mealy finite state machine that sequences the RISC-SPM datapath: the instruction fetch, decode and execute cycles.
- Generates every load, increment and select strobe for the general registers R0–R3, the PC, the IR, the address register, the ALU operand/result registers Y and Z, the two bus multiplexers and the memory write enable.
- Sits beside the instruction register: its `instruction` input is driven by the IR output, and its `zero` input is driven by the zero flag register.

Parameters:
- ws, 8, instruction word width. Field positions are fixed:
  - opcode = instruction[ws-1:ws-4]
  - src = instruction[3:2]
  - dest = instruction[1:0]

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  synchronous, active-low reset
- instruction  input  ws  current IR contents
- zero  input  1  zero flag from the flag register
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load strobes
- Load_PC  output  1  load PC from Bus_2
- Inc_PC  output  1  increment PC
- Sel_Bus_1_Mux  output  3  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- Sel_Bus_2_Mux  output  2  Bus_2 source: 0=ALU, 1=Bus_1, 2=memory
- Load_IR  output  1  load instruction register
- Load_Add_R  output  1  load address register
- Load_Reg_Y  output  1  load ALU operand register Y
- Load_Reg_Z  output  1  load zero flag register
- write  output  1  memory write enable
- halted  output  1  high while in S_halt

Behaviour:
- Opcodes:
  - NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8
  - 9–15 are illegal.
- States: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt. The state register is 4 bits.
- Reset:
  - When rst=0 at a clk rising edge, state <= S_idle. This applies from any state, including mid-instruction.
  - All outputs are combinational. Every output is forced to 0 whenever rst=0, so write and loads cannot pulse during reset.
  - In S_idle all outputs are 0.
- Default for every output in every state is 0. The per-state actions below list only asserted strobes.
- Per-state actions and next state:
  - S_idle → S_fet1. No strobes.
  - S_fet1: Sel_Bus_1_Mux=PC, Sel_Bus_2_Mux=Bus_1, Load_Add_R → S_fet2.
  - S_fet2: Sel_Bus_2_Mux=mem, Load_IR, Inc_PC → S_dec.
  - S_dec (Mealy on the opcode and zero):
    - NOP: → S_fet1.
    - ADD/SUB/AND: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=Bus_1, Load_Reg_Y → S_ex1.
    - NOT: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=ALU, Load_Reg_Z, Load_R[dest] → S_fet1.
    - RD: Sel_Bus_1_Mux=PC, Sel_Bus_2_Mux=Bus_1, Load_Add_R → S_rd1.
    - WR: same strobes as RD → S_wr1.
    - BR: same strobes as RD → S_br1.
    - BRZ with zero=1: same strobes as BR → S_br1.
    - BRZ with zero=0: Inc_PC (skips the address byte) → S_fet1.
    - Illegal opcode: → S_halt.
  - S_ex1: Sel_Bus_1_Mux=dest, Sel_Bus_2_Mux=ALU, Load_Reg_Z, Load_R[dest] → S_fet1.
  - S_rd1: Sel_Bus_2_Mux=mem, Load_Add_R, Inc_PC → S_rd2.
  - S_rd2: Sel_Bus_2_Mux=mem, Load_R[dest] → S_fet1.
  - S_wr1: Sel_Bus_2_Mux=mem, Load_Add_R, Inc_PC → S_wr2.
  - S_wr2: Sel_Bus_1_Mux=src, write → S_fet1.
  - S_br1: Sel_Bus_2_Mux=mem, Load_Add_R → S_br2.
  - S_br2: Sel_Bus_2_Mux=mem, Load_PC → S_fet1.
  - S_halt: stays in S_halt with halted=1. Only reset exits it.
  - Unused state encodings → S_idle.
- Load_R[n] asserts exactly one of Load_R0..Load_R3, selected by n.
- Instruction cycle counts, each measured from entering S_fet1:
  - NOP: 3 cycles.
  - NOT: 3 cycles.
  - ADD/SUB/AND: 4 cycles.
  - BRZ not taken: 3 cycles.
  - RD, WR, BR, BRZ taken: 5 cycles.
- At most one Load_R* asserts per cycle.
- write asserts only in S_wr2.
- Load_PC and Inc_PC are never asserted together.

Test Plan:
- Reset release, instruction=8'h00 (NOP) → idle, fet1, fet2, dec, fet1.
  - Load_IR=1 only in fet2.
  - Inc_PC=1 only in fet2.
- instruction=8'h16 (ADD R1→R2):
  - In dec: Sel_Bus_1_Mux=1, Load_Reg_Y=1.
  - In ex1: Sel_Bus_1_Mux=2, Sel_Bus_2_Mux=0, Load_R2=1, Load_Reg_Z=1.
  - Then fet1.
- instruction=8'h63 (WR, src R0):
  - wr1: Inc_PC=1.
  - wr2: write=1, Sel_Bus_1_Mux=0.
  - No Load_R* asserts anywhere in the sequence.
- instruction=8'h80 (BRZ), with zero=0 then zero=1:
  - zero=0: dec asserts Inc_PC, next state fet1.
  - zero=1: br1 follows, then br2 with Load_PC=1, Sel_Bus_2_Mux=2.
- instruction=8'hF0 (illegal) → halted=1 from the cycle after dec and held for 10+ cycles with all strobes 0.
  - rst=0 for one edge → idle, halted=0.
- rst=0 asserted combinationally during wr2 → write drops to 0 immediately; state is S_idle after the edge.

Source files
------------

// File: rtl/risc_spm_control_unit.sv
// rtl/risc_spm_control_unit.sv - RISC-SPM fetch/decode/execute sequencer
// Drives every datapath strobe; outputs are combinational from state, IR, zero flag and reset.
module risc_spm_control_unit #(
  parameter int ws = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [ws-1:0] instruction,
  input  logic          zero,
  output logic          Load_R0,
  output logic          Load_R1,
  output logic          Load_R2,
  output logic          Load_R3,
  output logic          Load_PC,
  output logic          Inc_PC,
  output logic [2:0]    Sel_Bus_1_Mux,
  output logic [1:0]    Sel_Bus_2_Mux,
  output logic          Load_IR,
  output logic          Load_Add_R,
  output logic          Load_Reg_Y,
  output logic          Load_Reg_Z,
  output logic          write,
  output logic          halted
);

  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_PC   = 3'd4;
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic       load_r_en;
  logic [1:0] load_r_sel;
  logic [3:0] load_r_vec;

  assign opcode = instruction[ws-1:ws-4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= S_idle;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    load_r_en     = 1'b0;
    load_r_sel    = 2'd0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Sel_Bus_1_Mux = 3'd0;
    Sel_Bus_2_Mux = 2'd0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;

    case (state)
      S_idle: next_state = S_fet1;
      S_fet1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_BUS1;
        Load_Add_R    = 1'b1;
        next_state    = S_fet2;
      end
      S_fet2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        next_state    = S_dec;
      end
      S_dec: begin
        case (opcode)
          OP_NOP: next_state = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            Sel_Bus_1_Mux = {1'b0, src};
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            next_state    = S_ex1;
          end
          OP_NOT: begin
            Sel_Bus_1_Mux = {1'b0, src};
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            load_r_en     = 1'b1;
            load_r_sel    = dest;
            next_state    = S_fet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            Sel_Bus_1_Mux = SEL1_PC;
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Add_R    = 1'b1;
            next_state    = (opcode == OP_RD) ? S_rd1 :
                            (opcode == OP_WR) ? S_wr1 : S_br1;
          end
          OP_BRZ: begin
            if (zero) begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Add_R    = 1'b1;
              next_state    = S_br1;
            end else begin
              // untaken branch steps the PC over the target address byte
              Inc_PC     = 1'b1;
              next_state = S_fet1;
            end
          end
          default: next_state = S_halt;
        endcase
      end
      S_ex1: begin
        Sel_Bus_1_Mux = {1'b0, dest};
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        load_r_en     = 1'b1;
        load_r_sel    = dest;
        next_state    = S_fet1;
      end
      S_rd1, S_wr1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        next_state    = (state == S_rd1) ? S_rd2 : S_wr2;
      end
      S_rd2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        load_r_en     = 1'b1;
        load_r_sel    = dest;
        next_state    = S_fet1;
      end
      S_wr2: begin
        Sel_Bus_1_Mux = {1'b0, src};
        write         = 1'b1;
        next_state    = S_fet1;
      end
      S_br1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        next_state    = S_br2;
      end
      S_br2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        next_state    = S_fet1;
      end
      S_halt: begin
        halted     = 1'b1;
        next_state = S_halt;
      end
      default: next_state = S_idle;
    endcase

    // reset masks every strobe so nothing can pulse while rst is low
    if (!rst) begin
      load_r_en     = 1'b0;
      Load_PC       = 1'b0;
      Inc_PC        = 1'b0;
      Sel_Bus_1_Mux = 3'd0;
      Sel_Bus_2_Mux = 2'd0;
      Load_IR       = 1'b0;
      Load_Add_R    = 1'b0;
      Load_Reg_Y    = 1'b0;
      Load_Reg_Z    = 1'b0;
      write         = 1'b0;
      halted        = 1'b0;
    end
  end

  assign load_r_vec = load_r_en ? (4'b0001 << load_r_sel) : 4'b0000;
  assign Load_R0    = load_r_vec[0];
  assign Load_R1    = load_r_vec[1];
  assign Load_R2    = load_r_vec[2];
  assign Load_R3    = load_r_vec[3];

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// tb/tb_risc_spm_control_unit.sv - cycle-by-cycle vector bench for the RISC-SPM control unit
module tb_risc_spm_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted;

  int checks = 0;
  int errors = 0;

  risc_spm_control_unit #(.ws(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
    .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {R3,R2,R1,R0, Load_PC, Inc_PC, Sel1[2:0], Sel2[1:0], IR, AddR, Y, Z, write, halted}
  logic [16:0] act;
  assign act = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
                Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted};

  function automatic logic [16:0] o(input logic [3:0] lr, input logic lpc, input logic ipc,
                                    input logic [2:0] s1, input logic [1:0] s2, input logic ir,
                                    input logic ar, input logic y, input logic z,
                                    input logic w, input logic h);
    return {lr, lpc, ipc, s1, s2, ir, ar, y, z, w, h};
  endfunction

  typedef struct {
    logic        rst;
    logic [7:0]  instr;
    logic        zero;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] i, input logic z,
                     input logic [16:0] e, input string n);
    vec_t v;
    v.rst = r; v.instr = i; v.zero = z; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
    checks++;
    if (($countones({Load_R0, Load_R1, Load_R2, Load_R3}) > 1) || (Load_PC && Inc_PC)) begin
      errors++;
      $display("FAIL %s_invariant: got loads=%b%b%b%b pc=%b%b expected one-hot-or-zero and no pc conflict",
               name, Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic [7:0] i, input logic z,
                       input logic [16:0] e, input string n);
    rst = r; instruction = i; zero = z;
    #1;
    check(n, e);
    next_cycle();
  endtask

  logic [16:0] ZERO, F1, F2, ADDR_LD, H;

  initial begin
    ZERO    = '0;
    F1      = o(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
    F2      = o(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
    ADDR_LD = F1;
    H       = o(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);

    add(0, 8'h00, 0, ZERO, "reset0");
    add(0, 8'h00, 0, ZERO, "reset1");
    add(1, 8'h00, 0, ZERO, "idle");
    add(1, 8'h00, 0, F1,   "nop_fet1");
    add(1, 8'h00, 0, F2,   "nop_fet2");
    add(1, 8'h00, 0, ZERO, "nop_dec");
    add(1, 8'h00, 0, F1,   "add_fet1");
    add(1, 8'h16, 0, F2,   "add_fet2");
    add(1, 8'h16, 0, o(4'b0000, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0), "add_dec");
    add(1, 8'h16, 0, o(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0), "add_ex1");
    add(1, 8'h16, 0, F1,   "wr_fet1");
    add(1, 8'h63, 0, F2,   "wr_fet2");
    add(1, 8'h63, 0, ADDR_LD, "wr_dec");
    add(1, 8'h63, 0, o(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "wr_wr1");
    add(1, 8'h63, 0, o(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0), "wr_wr2");
    add(1, 8'h63, 0, F1,   "brz0_fet1");
    add(1, 8'h80, 0, F2,   "brz0_fet2");
    add(1, 8'h80, 0, o(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0), "brz0_dec");
    add(1, 8'h80, 1, F1,   "brz1_fet1");
    add(1, 8'h80, 1, F2,   "brz1_fet2");
    add(1, 8'h80, 1, ADDR_LD, "brz1_dec");
    add(1, 8'h80, 1, o(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "brz1_br1");
    add(1, 8'h80, 1, o(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "brz1_br2");
    add(1, 8'h80, 0, F1,   "rd_fet1");
    add(1, 8'h5B, 0, F2,   "rd_fet2");
    add(1, 8'h5B, 0, ADDR_LD, "rd_dec");
    add(1, 8'h5B, 0, o(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "rd_rd1");
    add(1, 8'h5B, 0, o(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "rd_rd2");
    add(1, 8'h5B, 0, F1,   "not_fet1");
    add(1, 8'h47, 0, F2,   "not_fet2");
    add(1, 8'h47, 0, o(4'b1000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0), "not_dec");
    add(1, 8'h47, 0, F1,   "br_fet1");
    add(1, 8'h70, 0, F2,   "br_fet2");
    add(1, 8'h70, 0, ADDR_LD, "br_dec");
    add(1, 8'h70, 0, o(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "br_br1");
    add(1, 8'h70, 0, o(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "br_br2");
    add(1, 8'h70, 0, F1,   "sub_fet1");
    add(1, 8'h2D, 0, F2,   "sub_fet2");
    add(1, 8'h2D, 0, o(4'b0000, 0, 0, 3'd3, 2'd1, 0, 0, 1, 0, 0, 0), "sub_dec");
    add(1, 8'h2D, 0, o(4'b0010, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0), "sub_ex1");
    add(1, 8'h2D, 0, F1,   "and_fet1");
    add(1, 8'h3C, 0, F2,   "and_fet2");
    add(1, 8'h3C, 0, o(4'b0000, 0, 0, 3'd3, 2'd1, 0, 0, 1, 0, 0, 0), "and_dec");
    add(1, 8'h3C, 0, o(4'b0001, 0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0), "and_ex1");
    add(1, 8'h3C, 0, F1,   "ill_fet1");
    add(1, 8'hF0, 0, F2,   "ill_fet2");
    add(1, 8'hF0, 0, ZERO, "ill_dec");

    rst = 1'b0; instruction = 8'h00; zero = 1'b0;
    @(negedge clk);
    foreach (vecs[k]) apply(vecs[k].rst, vecs[k].instr, vecs[k].zero, vecs[k].exp, vecs[k].name);

    // halt must hold with no strobes regardless of IR and zero flag
    for (int i = 0; i < 12; i++) apply(1, (i % 2 == 0) ? 8'h00 : 8'h63, i[0], H, "halt_hold");
    apply(0, 8'h00, 0, ZERO, "halt_reset");
    apply(1, 8'h00, 0, ZERO, "halt_exit_idle");
    apply(1, 8'h00, 0, F1,   "post_halt_fet1");

    // reset pulled low mid-write: write must drop without waiting for an edge
    apply(1, 8'h6B, 0, F2,      "rwr_fet2");
    apply(1, 8'h6B, 0, ADDR_LD, "rwr_dec");
    apply(1, 8'h6B, 0, o(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "rwr_wr1");
    rst = 1'b1; #1;
    check("rwr_wr2", o(4'b0000, 0, 0, 3'd2, 2'd0, 0, 0, 0, 0, 1, 0));
    rst = 1'b0; #1;
    check("rwr_write_drop", ZERO);
    next_cycle();
    apply(1, 8'h6B, 0, ZERO, "rwr_idle");
    apply(1, 8'h6B, 0, F1,   "rwr_fet1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
